pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 16-register, 4-bit-opcode pipelined core.
- Merges four stall/flush sources into per-stage write enables and flush controls: load-use hazard, taken-branch flush, multi-cycle data-memory handshake, and HLT (opcode 4'b1111) drain/halt.
- Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Also keeps a saturating stall-cycle counter and a memory-timeout error flag.

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/pipe_ctrl_load_use_detect.sv | 15 +
 rtl/pipe_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencer: opcode/register widths,
// sequencer states and the bundle of per-stage enable/flush controls.
package pipe_pkg;

    localparam int REG_IDX_W = 4;
    localparam int OPC_W     = 4;

    localparam logic [OPC_W-1:0] OP_HLT = 4'b1111;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } pipe_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_write;
    } pipe_ctrl_t;

    // Canonical control patterns used by the sequencer
    localparam pipe_ctrl_t CTRL_IDLE  = pipe_ctrl_t'(6'b000000);
    localparam pipe_ctrl_t CTRL_RUN   = pipe_ctrl_t'(6'b110011);
    localparam pipe_ctrl_t CTRL_HOLD  = pipe_ctrl_t'(6'b000111);
    localparam pipe_ctrl_t CTRL_FLUSH = pipe_ctrl_t'(6'b111111);

    function automatic pipe_ctrl_t ctrl_gate(input pipe_ctrl_t c, input logic en);
        return pipe_ctrl_t'(c & {6{en}});
    endfunction

endpackage

// File: rtl/pipe_ctrl_load_use_detect.sv
// Load-use hazard compare: a load in ID/EX whose destination matches either
// source field of the instruction in IF/ID. Opcode-independent by design.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic                 id_ex_mr,
    input  logic [REG_IDX_W-1:0] id_ex_rt,
    input  logic [REG_IDX_W-1:0] if_id_rs,
    input  logic [REG_IDX_W-1:0] if_id_rt,
    output logic                 hazard
);

    assign hazard = id_ex_mr && ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges memory stall, branch flush, HLT drain/halt and
// load-use hazards into per-stage enables; keeps stall count and timeout flag.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPC_W-1:0]     if_id_opcode,
    input  logic [REG_IDX_W-1:0] if_id_rs,
    input  logic [REG_IDX_W-1:0] if_id_rt,
    input  logic [REG_IDX_W-1:0] id_ex_rt,
    input  logic                 id_ex_mr,
    input  logic                 ex_branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ack,
    input  logic                 resume,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_bubble,
    output logic                 ex_mem_write,
    output logic                 mem_wb_write,
    output logic                 halted,
    output logic                 mem_err,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);

    pipe_state_e         state_r;
    pipe_state_e         saved_r;
    logic [DRAIN_W-1:0]  drain_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic                mem_err_r;
    logic [CNT_W-1:0]    stall_cnt_r;

    pipe_state_e         state_next_s;
    pipe_state_e         saved_next_s;
    logic [DRAIN_W-1:0]  drain_next_s;
    logic [WAIT_W-1:0]   wait_next_s;
    logic                mem_err_next_s;
    pipe_ctrl_t          ctrl_s;
    pipe_ctrl_t          ctrl_out_s;
    logic                eval_s;
    logic                eval_drain_s;
    logic                mem_stall_s;
    logic                load_use_s;
    logic                stall_inc_s;

    load_use_detect u_load_use (
        .id_ex_mr (id_ex_mr),
        .id_ex_rt (id_ex_rt),
        .if_id_rs (if_id_rs),
        .if_id_rt (if_id_rt),
        .hazard   (load_use_s)
    );

    assign mem_stall_s = mem_req && !mem_ack;

    // Next-state and control decode; an acked MEM_WAIT cycle re-evaluates as the saved state
    always_comb begin
        state_next_s   = state_r;
        saved_next_s   = saved_r;
        drain_next_s   = drain_cnt_r;
        wait_next_s    = wait_cnt_r;
        mem_err_next_s = mem_err_r;
        ctrl_s         = CTRL_IDLE;
        eval_s         = 1'b0;
        eval_drain_s   = 1'b0;

        case (state_r)
            RUN, DRAIN: begin
                if (mem_stall_s) begin
                    state_next_s = MEM_WAIT;
                    saved_next_s = state_r;
                    wait_next_s  = '0;
                end else begin
                    eval_s       = 1'b1;
                    eval_drain_s = (state_r == DRAIN);
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    eval_s       = 1'b1;
                    eval_drain_s = (saved_r == DRAIN);
                    wait_next_s  = '0;
                end else if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    mem_err_next_s = 1'b1;
                    state_next_s   = HALTED;
                    wait_next_s    = '0;
                end else begin
                    wait_next_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            HALTED: begin
                if (resume) begin
                    ctrl_s       = CTRL_RUN;
                    state_next_s = RUN;
                end else begin
                    ctrl_s = CTRL_IDLE;
                end
            end
            default: begin
                state_next_s = RUN;
            end
        endcase

        // Memory-ready priorities: branch, drain/HLT, load-use, free run
        if (eval_s) begin
            if (ex_branch_taken) begin
                ctrl_s       = CTRL_FLUSH;
                state_next_s = RUN;
                drain_next_s = '0;
            end else if (eval_drain_s) begin
                ctrl_s = CTRL_HOLD;
                if (drain_cnt_r == '0) begin
                    state_next_s = HALTED;
                end else begin
                    drain_next_s = drain_cnt_r - DRAIN_W'(1);
                    state_next_s = DRAIN;
                end
            end else if (if_id_opcode == OP_HLT) begin
                ctrl_s       = CTRL_HOLD;
                state_next_s = DRAIN;
                drain_next_s = DRAIN_W'(DRAIN_CYCLES - 1);
            end else if (load_use_s) begin
                ctrl_s       = CTRL_HOLD;
                state_next_s = RUN;
            end else begin
                ctrl_s       = CTRL_RUN;
                state_next_s = RUN;
            end
        end else begin
            ctrl_s = ctrl_s;
        end
    end

    assign stall_inc_s = !ctrl_s.pc_write && (state_r != HALTED) && (stall_cnt_r != {CNT_W{1'b1}});

    // Sequencer state, drain/wait counters, sticky error and saturating stall count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RUN;
            saved_r     <= RUN;
            drain_cnt_r <= '0;
            wait_cnt_r  <= '0;
            mem_err_r   <= 1'b0;
            stall_cnt_r <= '0;
        end else begin
            state_r     <= state_next_s;
            saved_r     <= saved_next_s;
            drain_cnt_r <= drain_next_s;
            wait_cnt_r  <= wait_next_s;
            mem_err_r   <= mem_err_next_s;
            if (stall_inc_s) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    // Enables must read as zero while reset is held, independent of the inputs
    assign ctrl_out_s   = ctrl_gate(ctrl_s, rst_n);
    assign pc_write     = ctrl_out_s.pc_write;
    assign if_id_write  = ctrl_out_s.if_id_write;
    assign if_id_flush  = ctrl_out_s.if_id_flush;
    assign id_ex_bubble = ctrl_out_s.id_ex_bubble;
    assign ex_mem_write = ctrl_out_s.ex_mem_write;
    assign mem_wb_write = ctrl_out_s.mem_wb_write;
    assign halted       = rst_n && (state_r == HALTED);
    assign mem_err      = mem_err_r;
    assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed table-driven bench for pipe_ctrl (MEM_TIMEOUT reduced to 8), plus a
// hand-written asynchronous reset sequence taken from inside MEM_WAIT.
module tb_pipe_ctrl;

    localparam logic [5:0] C_IDLE  = 6'b000000;
    localparam logic [5:0] C_RUN   = 6'b110011;
    localparam logic [5:0] C_HOLD  = 6'b000111;
    localparam logic [5:0] C_FLUSH = 6'b111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  if_id_opcode, if_id_rs, if_id_rt, id_ex_rt;
    logic        id_ex_mr, ex_branch_taken, mem_req, mem_ack, resume;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_write;
    logic        halted, mem_err;
    logic [15:0] stall_cnt;

    typedef struct {
        logic [3:0]  opc, rs, rt, ex_rt;
        logic        mr, br, req, ack, res;
        logic [5:0]  ctrl;
        logic        h, e;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_fail = 0;

    pipe_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_id_opcode(if_id_opcode), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .id_ex_rt(id_ex_rt), .id_ex_mr(id_ex_mr), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack), .resume(resume),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] opc, rs, rt, ex_rt,
                                input logic mr, br, req, ack, res,
                                input logic [5:0] ctrl, input logic h, e, input logic [15:0] cnt);
        vec_t v;
        v.opc = opc; v.rs = rs; v.rt = rt; v.ex_rt = ex_rt;
        v.mr = mr; v.br = br; v.req = req; v.ack = ack; v.res = res;
        v.ctrl = ctrl; v.h = h; v.e = e; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [5:0] ctrl_now();
        return {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_write};
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        if_id_opcode = v.opc; if_id_rs = v.rs; if_id_rt = v.rt; id_ex_rt = v.ex_rt;
        id_ex_mr = v.mr; ex_branch_taken = v.br; mem_req = v.req; mem_ack = v.ack; resume = v.res;
    endtask

    task automatic check_all(input int idx, input logic [5:0] c, input logic h, e, input logic [15:0] cnt);
        chk("ctrl", idx, {10'd0, ctrl_now()}, {10'd0, c});
        chk("halted", idx, {15'd0, halted}, {15'd0, h});
        chk("mem_err", idx, {15'd0, mem_err}, {15'd0, e});
        chk("stall_cnt", idx, stall_cnt, cnt);
    endtask

    initial begin
        // Load-use hit on Rs, then miss, then hit on Rt
        vecs.push_back(mk(4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(4'h0, 4'h5, 4'h2, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_HOLD,  1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b0, 16'd1));
        vecs.push_back(mk(4'h0, 4'h3, 4'h4, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b0, 16'd1));
        vecs.push_back(mk(4'h0, 4'h3, 4'h5, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_HOLD,  1'b0, 1'b0, 16'd1));
        // Memory wait: 4 stalled cycles then ack
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_IDLE, 1'b0, 1'b0, 16'(2 + i)));
        vecs.push_back(mk(4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_RUN,   1'b0, 1'b0, 16'd6));
        vecs.push_back(mk(4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b0, 16'd6));
        // Branch beats load-use
        vecs.push_back(mk(4'h0, 4'h5, 4'h2, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH, 1'b0, 1'b0, 16'd6));
        vecs.push_back(mk(4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b0, 16'd6));
        // HLT: entry + 3 drain cycles, halted, ignored inputs, resume
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(4'hF, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_HOLD, 1'b0, 1'b0, 16'(6 + i)));
        vecs.push_back(mk(4'hF, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE,  1'b1, 1'b0, 16'd10));
        vecs.push_back(mk(4'hF, 4'h1, 4'h2, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_IDLE,  1'b1, 1'b0, 16'd10));
        vecs.push_back(mk(4'hF, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_RUN,   1'b1, 1'b0, 16'd10));
        vecs.push_back(mk(4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b0, 16'd10));
        // Branch in first drain cycle cancels the halt; stray resume ignored
        vecs.push_back(mk(4'hF, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_HOLD,  1'b0, 1'b0, 16'd10));
        vecs.push_back(mk(4'hF, 4'h1, 4'h2, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH, 1'b0, 1'b0, 16'd11));
        vecs.push_back(mk(4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b0, 16'd11));
        vecs.push_back(mk(4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_RUN,   1'b0, 1'b0, 16'd11));
        // Memory stall inside DRAIN, ack resumes the drain countdown
        vecs.push_back(mk(4'hF, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_HOLD,  1'b0, 1'b0, 16'd11));
        vecs.push_back(mk(4'hF, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_IDLE,  1'b0, 1'b0, 16'd12));
        vecs.push_back(mk(4'hF, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_HOLD,  1'b0, 1'b0, 16'd13));
        vecs.push_back(mk(4'hF, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_HOLD,  1'b0, 1'b0, 16'd14));
        vecs.push_back(mk(4'hF, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_HOLD,  1'b0, 1'b0, 16'd15));
        vecs.push_back(mk(4'hF, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE,  1'b1, 1'b0, 16'd16));
        vecs.push_back(mk(4'hF, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_RUN,   1'b1, 1'b0, 16'd16));
        vecs.push_back(mk(4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b0, 16'd16));
        // Timeout: RUN stall cycle + 8 MEM_WAIT cycles without ack
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk(4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_IDLE, 1'b0, 1'b0, 16'(16 + i)));
        vecs.push_back(mk(4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_IDLE,  1'b1, 1'b1, 16'd25));
        vecs.push_back(mk(4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_RUN,   1'b1, 1'b1, 16'd25));
        vecs.push_back(mk(4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b1, 16'd25));

        // Reset state with idle inputs: enables forced low
        drive(vecs[0]);
        @(negedge clk);
        #1;
        check_all(-1, C_IDLE, 1'b0, 1'b0, 16'd0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_all(i, vecs[i].ctrl, vecs[i].h, vecs[i].e, vecs[i].cnt);
        end

        // Async reset from inside MEM_WAIT, with mem_err set beforehand
        @(negedge clk);
        drive(mk(4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_IDLE, 1'b0, 1'b0, 16'd0));
        #1;
        check_all(100, C_IDLE, 1'b0, 1'b1, 16'd25);
        @(negedge clk);
        #1;
        check_all(101, C_IDLE, 1'b0, 1'b1, 16'd26);
        drive(vecs[0]);
        #1 rst_n = 1'b0;
        #1;
        check_all(102, C_IDLE, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_all(103, C_RUN, 1'b0, 1'b0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
